// File: rtl/jtdsp16_pkg.sv
// Shared encodings for the DSP16 Y-space address arithmetic unit.
package jtdsp16_pkg;

  localparam logic [2:0] MOD_HOLD = 3'd0;
  localparam logic [2:0] MOD_INC  = 3'd1;
  localparam logic [2:0] MOD_DEC  = 3'd2;
  localparam logic [2:0] MOD_INCJ = 3'd3;
  localparam logic [2:0] MOD_INCK = 3'd4;

  localparam logic [2:0] SEL_R0 = 3'd0;
  localparam logic [2:0] SEL_R1 = 3'd1;
  localparam logic [2:0] SEL_R2 = 3'd2;
  localparam logic [2:0] SEL_R3 = 3'd3;
  localparam logic [2:0] SEL_RB = 3'd4;
  localparam logic [2:0] SEL_RE = 3'd5;
  localparam logic [2:0] SEL_J  = 3'd6;
  localparam logic [2:0] SEL_K  = 3'd7;

endpackage

// File: rtl/jtdsp16_yaau_next.sv
// Next-pointer computation: post-modify of one pointer, modulo 2^AW.
module jtdsp16_yaau_next
  import jtdsp16_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic [AW-1:0] r,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] j,
  input  logic [AW-1:0] k,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] re,
  output logic [AW-1:0] next_r
);

  // j and k are two's complement, so a plain AW-bit add also covers negative steps.
  always_comb begin
    next_r = r;
    case (mode)
      MOD_INC:  next_r = ((re != '0) && (r == re)) ? rb : r + AW'(1);
      MOD_DEC:  next_r = r - AW'(1);
      MOD_INCJ: next_r = r + j;
      MOD_INCK: next_r = r + k;
      default:  next_r = r;
    endcase
  end

endmodule

// File: rtl/jtdsp16_yaau.sv
// Y-space AAU: pointer/increment/bounds registers, RAM address/write port and
// read-valid flag for the 2048x16 internal data RAM.
module jtdsp16_yaau
  import jtdsp16_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          acc_en,
  input  logic          acc_we,
  input  logic [1:0]    ptr_sel,
  input  logic [2:0]    mod_mode,
  input  logic [DW-1:0] wdata,
  input  logic          reg_load,
  input  logic [2:0]    reg_sel,
  input  logic [DW-1:0] reg_din,
  output logic [DW-1:0] reg_dout,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic          rdata_valid
);

  logic [AW-1:0] r [4];
  logic [AW-1:0] rb, re, j, k;
  logic [AW-1:0] next_r;

  jtdsp16_yaau_next #(.AW(AW)) u_next (
    .r      (r[ptr_sel]),
    .mode   (mod_mode),
    .j      (j),
    .k      (k),
    .rb     (rb),
    .re     (re),
    .next_r (next_r)
  );

  // Access protocol: acc_en is a one-cycle strobe with no back-pressure; every
  // enabled cycle with acc_en high is one RAM access, presented combinationally
  // and captured by the RAM on the same edge that post-modifies the pointer.
  assign ram_addr = r[ptr_sel];
  assign ram_din  = wdata;
  assign ram_we   = rst_n & cen & acc_en & acc_we;

  // The load is written after the modify so it takes precedence on the same pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r[i] <= '0;
      rb          <= '0;
      re          <= '0;
      j           <= '0;
      k           <= '0;
      rdata_valid <= 1'b0;
    end else if (cen) begin
      if (acc_en) r[ptr_sel] <= next_r;
      if (reg_load) begin
        case (reg_sel)
          SEL_RB:  rb <= reg_din[AW-1:0];
          SEL_RE:  re <= reg_din[AW-1:0];
          SEL_J:   j  <= reg_din[AW-1:0];
          SEL_K:   k  <= reg_din[AW-1:0];
          default: r[reg_sel[1:0]] <= reg_din[AW-1:0];
        endcase
      end
      rdata_valid <= acc_en & ~acc_we;
    end
  end

  always_comb begin
    reg_dout = '0;
    case (reg_sel)
      SEL_RB:  reg_dout = {{(DW-AW){1'b0}}, rb};
      SEL_RE:  reg_dout = {{(DW-AW){1'b0}}, re};
      SEL_J:   reg_dout = {{(DW-AW){j[AW-1]}}, j};
      SEL_K:   reg_dout = {{(DW-AW){k[AW-1]}}, k};
      default: reg_dout = {{(DW-AW){1'b0}}, r[reg_sel[1:0]]};
    endcase
  end

endmodule

// File: tb/tb_jtdsp16_yaau.sv
// Bench for jtdsp16_yaau: directed scenarios plus random traffic against an
// arithmetic model of the register file and access rules.
module tb_jtdsp16_yaau;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic          acc_en = 1'b0;
  logic          acc_we = 1'b0;
  logic [1:0]    ptr_sel = '0;
  logic [2:0]    mod_mode = '0;
  logic [DW-1:0] wdata = '0;
  logic          reg_load = 1'b0;
  logic [2:0]    reg_sel = '0;
  logic [DW-1:0] reg_din = '0;
  logic [DW-1:0] reg_dout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic          rdata_valid;

  jtdsp16_yaau #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .acc_en(acc_en), .acc_we(acc_we),
    .ptr_sel(ptr_sel), .mod_mode(mod_mode), .wdata(wdata),
    .reg_load(reg_load), .reg_sel(reg_sel), .reg_din(reg_din),
    .reg_dout(reg_dout), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .rdata_valid(rdata_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  int unsigned m_r [4];
  int unsigned m_rb, m_re, m_j, m_k;
  int unsigned m_valid;
  logic [AW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_rb = 0; m_re = 0; m_j = 0; m_k = 0; m_valid = 0;
  endfunction

  function automatic int unsigned model_next(int unsigned r, int unsigned mode);
    case (mode)
      1: return (m_re != 0 && r == m_re) ? m_rb : (r + 1) % 2048;
      2: return (r + 2047) % 2048;
      3: return (r + m_j) % 2048;
      4: return (r + m_k) % 2048;
      default: return r;
    endcase
  endfunction

  function automatic int unsigned model_dout(int unsigned sel);
    int unsigned v;
    case (sel)
      4: v = m_rb;
      5: v = m_re;
      6: v = (m_j >= 1024) ? m_j + 16'hF800 : m_j;
      7: v = (m_k >= 1024) ? m_k + 16'hF800 : m_k;
      default: v = m_r[sel];
    endcase
    return v & 16'hFFFF;
  endfunction

  // Applied at each rising edge using the inputs that were held through the cycle.
  function automatic void model_update();
    int unsigned nxt;
    if (rst_n !== 1'b1 || cen !== 1'b1) return;
    nxt = model_next(m_r[ptr_sel], mod_mode);
    if (acc_en) m_r[ptr_sel] = nxt;
    if (reg_load) begin
      case (reg_sel)
        4: m_rb = reg_din % 2048;
        5: m_re = reg_din % 2048;
        6: m_j  = reg_din % 2048;
        7: m_k  = reg_din % 2048;
        default: m_r[reg_sel] = reg_din % 2048;
      endcase
    end
    m_valid = (acc_en && !acc_we) ? 1 : 0;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("ram_addr", ram_addr, m_r[ptr_sel]);
    check("ram_din", ram_din, wdata);
    check("ram_we", ram_we, (rst_n && cen && acc_en && acc_we) ? 1 : 0);
    check("rdata_valid", rdata_valid, m_valid);
    check("reg_dout", reg_dout, model_dout(reg_sel));
    if (rst_n && cen && acc_en && exp_q.size() > 0)
      check("addr_seq", ram_addr, exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic c, input logic ae, input logic aw,
                       input logic [1:0] ps, input logic [2:0] mm,
                       input logic ld, input logic [2:0] rs, input logic [DW-1:0] din);
    cen = c; acc_en = ae; acc_we = aw; ptr_sel = ps; mod_mode = mm;
    reg_load = ld; reg_sel = rs; reg_din = din; wdata = DW'($urandom);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic load(input logic [2:0] sel, input logic [DW-1:0] v);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, sel, v);
  endtask

  task automatic access(input logic [1:0] ps, input logic [2:0] mm, input logic we);
    drive(1'b1, 1'b1, we, ps, mm, 1'b0, 3'd0, '0);
  endtask

  // Idle cycle reading one register, with a literal expectation.
  task automatic peek(input logic [2:0] sel, input int unsigned exp);
    acc_en = 1'b0; reg_load = 1'b0; reg_sel = sel;
    #1;
    check("peek_reg", reg_dout, exp);
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_we", ram_we, 0);
    rst_n = 1'b1;
    cen = 1'b1;
    peek(3'd0, 0);
    peek(3'd6, 0);

    // Writes through r1 with ++.
    load(3'd1, 16'h0010);
    exp_q.push_back(11'h010); exp_q.push_back(11'h011); exp_q.push_back(11'h012);
    repeat (3) access(2'd1, 3'd1, 1'b1);
    peek(3'd1, 16'h0013);

    // Circular buffer reads on r0.
    load(3'd4, 16'h0020);
    load(3'd5, 16'h0023);
    load(3'd0, 16'h0022);
    exp_q.push_back(11'h022); exp_q.push_back(11'h023);
    exp_q.push_back(11'h020); exp_q.push_back(11'h021);
    for (int i = 0; i < 4; i++) begin
      access(2'd0, 3'd1, 1'b0);
      check("rd_valid_hi", rdata_valid, 1);
    end
    peek(3'd0, 16'h0022);
    check("rd_valid_lo", rdata_valid, 0);

    // Signed increments j and k.
    load(3'd6, 16'h07FE);
    load(3'd2, 16'h0001);
    exp_q.push_back(11'h001); exp_q.push_back(11'h7FF);
    repeat (2) access(2'd2, 3'd3, 1'b0);
    peek(3'd2, 16'h07FD);
    peek(3'd6, 16'hFFFE);
    load(3'd7, 16'h0005);
    access(2'd2, 3'd4, 1'b0);
    peek(3'd2, 16'h0002);

    // Wrap both ways with re = 0.
    load(3'd5, 16'h0000);
    load(3'd3, 16'h07FF);
    access(2'd3, 3'd1, 1'b0);
    peek(3'd3, 16'h0000);
    access(2'd3, 3'd2, 1'b0);
    peek(3'd3, 16'h07FF);

    // Load beats modify on the same pointer; access uses old pointer.
    load(3'd0, 16'h0050);
    exp_q.push_back(11'h050);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd1, 1'b1, 3'd0, 16'h0100);
    peek(3'd0, 16'h0100);

    // cen low: nothing changes, no write.
    drive(1'b0, 1'b1, 1'b1, 2'd0, 3'd1, 1'b1, 3'd0, 16'h0123);
    peek(3'd0, 16'h0100);
    cen = 1'b1;
    check("addr_q_empty", exp_q.size(), 0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), DW'($urandom));
    end

    // Asynchronous reset mid-write.
    load(3'd2, 16'h0155);
    cen = 1'b1; acc_en = 1'b1; acc_we = 1'b1; ptr_sel = 2'd2; mod_mode = 3'd1;
    reg_load = 1'b0;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_we_drop", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_valid", rdata_valid, 0);
    @(posedge clk);
    #1;
    cen = 1'b0;
    for (int s = 0; s < 8; s++) peek(3'(s), 0);
    rst_n = 1'b1;
    cen = 1'b1;
    peek(3'd2, 0);
    check("addr_q_final", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
